// File: rtl/powlib_dnfifo.sv
// Downsizing FIFO: buffers W*MULT-bit words and emits them as MULT W-bit slices, LS slice first.
// Optional rdlast output is enabled by defining POWLIB_DNFIFO_RDLAST_EN.
module powlib_dnfifo #(
  parameter int W    = 16,
  parameter int MULT = 3,
  parameter int D    = 4,
  parameter     ID   = "DNFIFO",
  parameter int EDBG = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W*MULT-1:0] wrdata,
  input  logic              wrvld,
  output logic              wrrdy,
  output logic [W-1:0]      rddata,
  output logic              rdvld,
  input  logic              rdrdy
`ifdef POWLIB_DNFIFO_RDLAST_EN
  ,
  output logic              rdlast
`endif
);

  localparam int AW      = $clog2(D);
  localparam int CW      = (MULT > 1) ? $clog2(MULT) : 1;
  localparam int ID_BITS = $bits(ID);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t              state;
  logic [W*MULT-1:0]   mem [D];
  logic [W*MULT-1:0]   sreg;
  logic [AW:0]         wrptr, rdptr, wrptr_nxt, rdptr_nxt;
  logic [CW-1:0]       cnt;
  logic                empty, full_nxt, last, push, pop_slice, load;

  // Debug tracing lives in simulation-side monitors; this block only keeps the knobs elaborated.
  if (EDBG != 0 && ID_BITS > 0) begin : g_edbg
  end

  assign empty     = (wrptr == rdptr);
  assign last      = (cnt == CW'(MULT - 1));
  assign push      = wrvld & wrrdy;
  assign pop_slice = rdvld & rdrdy;
  // Reload only from words already in the buffer before this edge, so no write bypass.
  assign load      = !empty & ((state == IDLE) | (pop_slice & last));
  assign wrptr_nxt = wrptr + {{AW{1'b0}}, push};
  assign rdptr_nxt = rdptr + {{AW{1'b0}}, load};
  assign full_nxt  = (wrptr_nxt[AW] != rdptr_nxt[AW]) &&
                     (wrptr_nxt[AW-1:0] == rdptr_nxt[AW-1:0]);

  always_ff @(posedge clk) begin
    if (push) mem[wrptr[AW-1:0]] <= wrdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrptr <= '0;
      rdptr <= '0;
      wrrdy <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else begin
      wrptr <= wrptr_nxt;
      rdptr <= rdptr_nxt;
      wrrdy <= !full_nxt;
      if (load) begin
        state <= SHIFT;
        sreg  <= mem[rdptr[AW-1:0]];
        cnt   <= '0;
      end else if (pop_slice) begin
        if (last) begin
          state <= IDLE;
        end else begin
          cnt  <= cnt + 1'b1;
          sreg <= sreg >> W;
        end
      end
    end
  end

  assign rdvld  = (state == SHIFT);
  assign rddata = sreg[W-1:0];

`ifdef POWLIB_DNFIFO_RDLAST_EN
  assign rdlast = rdvld & last;
`endif

endmodule

// File: tb/tb_powlib_dnfifo.sv
// Self-checking bench for powlib_dnfifo: W=16/MULT=3/D=4 instance against a slice-queue model,
// plus a W=8/MULT=1 instance checked by hand-written sequences.
module tb_powlib_dnfifo;

  localparam int W = 16;
  localparam int MULT = 3;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [47:0]   wrdata;
  logic          wrvld, wrrdy, rdvld, rdrdy;
  logic [15:0]   rddata;
  logic [7:0]    wrdata2, rddata2;
  logic          wrvld2, wrrdy2, rdvld2, rdrdy2;
`ifdef POWLIB_DNFIFO_RDLAST_EN
  logic          rdlast, rdlast2;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  powlib_dnfifo #(.W(W), .MULT(MULT), .D(D)) dut (
    .clk(clk), .rst(rst), .wrdata(wrdata), .wrvld(wrvld), .wrrdy(wrrdy),
    .rddata(rddata), .rdvld(rdvld), .rdrdy(rdrdy)
`ifdef POWLIB_DNFIFO_RDLAST_EN
    , .rdlast(rdlast)
`endif
  );

  powlib_dnfifo #(.W(8), .MULT(1), .D(4)) dut2 (
    .clk(clk), .rst(rst), .wrdata(wrdata2), .wrvld(wrvld2), .wrrdy(wrrdy2),
    .rddata(rddata2), .rdvld(rdvld2), .rdrdy(rdrdy2)
`ifdef POWLIB_DNFIFO_RDLAST_EN
    , .rdlast(rdlast2)
`endif
  );

  // Model: wide words held anywhere in the block, each tagged with the edge that wrote it.
  typedef struct {
    logic [47:0] data;
    int          wtime;
  } word_t;

  typedef struct {
    logic [47:0] wdata;
    logic [15:0] exp0;
    logic [15:0] exp1;
    logic [15:0] exp2;
  } vec_t;

  word_t q[$];
  int    idx = 0;
  int    cyc = 0;
  vec_t  tab[4];

  function automatic bit exp_rdvld();
    return (q.size() > 0) && (q[0].wtime < cyc);
  endfunction

  // One wide word may sit in the serializer; the remaining D slots form the buffer.
  function automatic bit exp_wrrdy();
    int in_buf;
    in_buf = q.size() - (exp_rdvld() ? 1 : 0);
    return (cyc > 0) && (in_buf < D);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: actual %0h, required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    bit rv, wr;
    rv = exp_rdvld();
    wr = exp_wrrdy();
    checkOutput("rdvld", {63'd0, rdvld}, {63'd0, rv});
    checkOutput("wrrdy", {63'd0, wrrdy}, {63'd0, wr});
    if (rv) checkOutput("rddata", {48'd0, rddata}, {48'd0, q[0].data[idx*W +: W]});
`ifdef POWLIB_DNFIFO_RDLAST_EN
    checkOutput("rdlast", {63'd0, rdlast}, {63'd0, rv && (idx == MULT - 1)});
`endif
    @(posedge clk);
    cyc++;
    if (wrvld && wr) q.push_back('{wrdata, cyc});
    if (rv && rdrdy) begin
      idx++;
      if (idx == MULT) begin
        void'(q.pop_front());
        idx = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    rdrdy = 1'b1;
    wrvld = 1'b0;
    while (q.size() > 0 && n < bound) begin
      tick();
      n++;
    end
    checkOutput("drain_empty", 64'(q.size()), 64'd0);
    tick();
  endtask

  task automatic applyStimulus(input logic [47:0] data);
    int n;
    bit acc;
    n = 0;
    wrdata = data;
    wrvld  = 1'b1;
    do begin
      acc = exp_wrrdy();
      tick();
      n++;
    end while (!acc && n < 10);
    checkOutput("write_accept", {63'd0, acc}, 64'd1);
    wrvld = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] b2b_exp[6];
    logic [15:0] e;
    int acc, sent, n;

    tab[0] = '{48'h0003_0002_0001, 16'h0001, 16'h0002, 16'h0003};
    tab[1] = '{48'hDEAD_BEEF_1234, 16'h1234, 16'hBEEF, 16'hDEAD};
    tab[2] = '{48'hFFFF_0000_8001, 16'h8001, 16'h0000, 16'hFFFF};
    tab[3] = '{48'h0F0F_A5A5_C33C, 16'hC33C, 16'hA5A5, 16'h0F0F};
    b2b_exp = '{16'h00A1, 16'h00A2, 16'h00A3, 16'h00B1, 16'h00B2, 16'h00B3};

    rst = 1'b1; wrdata = '0; wrvld = 1'b0; rdrdy = 1'b0;
    wrdata2 = '0; wrvld2 = 1'b0; rdrdy2 = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_rdvld", {63'd0, rdvld}, 64'd0);
    checkOutput("reset_wrrdy", {63'd0, wrrdy}, 64'd0);
    checkOutput("reset_rddata", {48'd0, rddata}, 64'd0);
    rst = 1'b0;
    q.delete(); idx = 0; cyc = 0;
    tick();

    // Table-driven single words: first slice two edges after the write, then idle.
    rdrdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wrdata = tab[i].wdata;
      wrvld  = 1'b1;
      tick();
      wrvld = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
        e = (k == 0) ? tab[i].exp0 : (k == 1) ? tab[i].exp1 : tab[i].exp2;
        checkOutput("tab_rdvld", {63'd0, rdvld}, 64'd1);
        checkOutput("tab_slice", {48'd0, rddata}, {48'd0, e});
        tick();
      end
      checkOutput("tab_idle", {63'd0, rdvld}, 64'd0);
    end

    // Back-to-back words stream without a bubble.
    wrdata = 48'h00A3_00A2_00A1; wrvld = 1'b1;
    tick();
    wrdata = 48'h00B3_00B2_00B1;
    tick();
    wrvld = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checkOutput("b2b_rdvld", {63'd0, rdvld}, 64'd1);
      checkOutput("b2b_slice", {48'd0, rddata}, {48'd0, b2b_exp[k]});
      tick();
    end
    checkOutput("b2b_idle", {63'd0, rdvld}, 64'd0);

    // Fill with the output stalled: capacity is D+1 wide words.
    rdrdy = 1'b0;
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      wrdata = {16'(3*i+3), 16'(3*i+2), 16'(3*i+1)};
      wrvld  = 1'b1;
      if (wrrdy) acc++;
      tick();
    end
    wrvld = 1'b0;
    checkOutput("fill_accepted", 64'(acc), 64'd5);
    checkOutput("fill_wrrdy_low", {63'd0, wrrdy}, 64'd0);
    rdrdy = 1'b1;
    tick();
    tick();
    checkOutput("fill_wrrdy_hold", {63'd0, wrrdy}, 64'd0);
    tick();
    checkOutput("fill_wrrdy_rise", {63'd0, wrrdy}, 64'd1);
    drain(40);

    // Random valid/ready over 20 words, crossing several pointer wraps.
    sent = 0;
    n = 0;
    while (sent < 20 && n < 3000) begin
      wrvld  = ($urandom_range(0, 3) != 0);
      wrdata = {16'($urandom), 32'($urandom)};
      rdrdy  = ($urandom_range(0, 1) != 0);
      if (wrvld && exp_wrrdy()) sent++;
      tick();
      n++;
    end
    checkOutput("rand_sent", 64'(sent), 64'd20);
    drain(200);

    // Reset in the middle of a word discards everything.
    rdrdy = 1'b1;
    wrdata = 48'h0003_0002_0001; wrvld = 1'b1;
    tick();
    wrvld = 1'b0;
    tick();
    checkOutput("midrst_slice0", {48'd0, rddata}, 64'h0001);
    tick();
    rst = 1'b1;
    #1;
    checkOutput("midrst_rdvld", {63'd0, rdvld}, 64'd0);
    checkOutput("midrst_wrrdy", {63'd0, wrrdy}, 64'd0);
    q.delete(); idx = 0; cyc = 0;
    #1 rst = 1'b0;
    applyStimulus(48'h0006_0005_0004);
    tick();
    checkOutput("midrst_new0", {48'd0, rddata}, 64'h0004);
    drain(20);

    // MULT=1 instance behaves as a plain FIFO with rdlast following rdvld.
    checkOutput("m1_wrrdy", {63'd0, wrrdy2}, 64'd1);
    wrdata2 = 8'h5A; wrvld2 = 1'b1;
    tick();
    wrdata2 = 8'hC3;
    tick();
    wrvld2 = 1'b0;
    checkOutput("m1_rdvld0", {63'd0, rdvld2}, 64'd1);
    checkOutput("m1_data0", {56'd0, rddata2}, 64'h5A);
`ifdef POWLIB_DNFIFO_RDLAST_EN
    checkOutput("m1_rdlast0", {63'd0, rdlast2}, 64'd1);
`endif
    tick();
    checkOutput("m1_rdvld1", {63'd0, rdvld2}, 64'd1);
    checkOutput("m1_data1", {56'd0, rddata2}, 64'hC3);
    tick();
    checkOutput("m1_idle", {63'd0, rdvld2}, 64'd0);
`ifdef POWLIB_DNFIFO_RDLAST_EN
    checkOutput("m1_rdlast_idle", {63'd0, rdlast2}, 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
